// File: rtl/muntjac_pkg.sv
// Shared muntjac types used by the fetch redirect controller and frontend.
package muntjac_pkg;

  typedef enum logic {
    FENCE_KIND_I   = 1'b0,
    FENCE_KIND_VMA = 1'b1
  } fence_kind_e;

  typedef enum logic [1:0] {
    RDR_IDLE  = 2'd0,
    RDR_DRAIN = 2'd1,
    RDR_ISSUE = 2'd2
  } redirect_state_e;

  typedef enum logic [3:0] {
    IF_PREFETCH     = 4'd0,
    IF_MISPREDICT   = 4'd1,
    IF_FENCE_I      = 4'd2,
    IF_SATP_CHANGED = 4'd3,
    IF_TRAP         = 4'd4
  } if_reason_e;

  typedef enum logic [2:0] {
    BRANCH_NONE    = 3'd0,
    BRANCH_JUMP    = 3'd1,
    BRANCH_CALL    = 3'd2,
    BRANCH_RET     = 3'd3,
    BRANCH_UNTAKEN = 3'd4,
    BRANCH_TAKEN   = 3'd5
  } branch_type_e;

  typedef struct packed {
    branch_type_e branch_type;
    logic [63:0]  pc;
    logic         compressed;
  } branch_info_t;

  // Slot of each source inside the 3x32 perf counter vector.
  localparam int unsigned PerfSrcTrap    = 2;
  localparam int unsigned PerfSrcFence   = 1;
  localparam int unsigned PerfSrcMispred = 0;

endpackage

// File: rtl/muntjac_redirect_perf.sv
// Per-source redirect counters; present only when MUNTJAC_REDIRECT_PERF_EN is defined.
module muntjac_redirect_perf (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [2:0]       inc_i,
  output logic [2:0][31:0] cnt_o
);

`ifdef MUNTJAC_REDIRECT_PERF_EN
  logic [2:0][31:0] cnt_p1;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_p1 <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (inc_i[i]) cnt_p1[i] <= cnt_p1[i] + 32'd1;
      end
    end
  end

  assign cnt_o = cnt_p1;
`else
  logic unused_perf;
  assign unused_perf = ^{clk_i, rst_ni, inc_i};
  assign cnt_o = '0;
`endif

endmodule

// File: rtl/muntjac_redirect_ctrl.sv
// Arbitrates trap / fence / mispredict redirects into one registered pulse for the frontend.
// Optional perf counters: define MUNTJAC_REDIRECT_PERF_EN.
module muntjac_redirect_ctrl
  import muntjac_pkg::*;
#(
  parameter int unsigned DrainTimeout = 1024
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             trap_valid_i,
  input  logic [63:0]      trap_pc_i,
  input  logic             fence_valid_i,
  input  fence_kind_e      fence_kind_i,
  input  logic [63:0]      fence_pc_i,
  input  logic             mispred_valid_i,
  input  logic [63:0]      mispred_pc_i,
  input  branch_info_t     branch_info_i,
  input  logic             dcache_idle_i,
  output logic             busy_o,
  output logic             redirect_valid_o,
  output if_reason_e       redirect_reason_o,
  output logic [63:0]      redirect_pc_o,
  output branch_info_t     branch_info_o,
  output logic             drain_timeout_o,
  output logic [2:0][31:0] perf_cnt_o
);

  localparam logic [31:0] TimeoutW  = 32'(DrainTimeout);
  localparam logic        TimeoutEn = (DrainTimeout != 0);

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  redirect_state_e state_q, state_d;

  logic         trap_acc, fence_issue, mis_acc, drain_enter;
  logic         vld_p0;
  if_reason_e   reason_p0;
  logic [63:0]  pc_p0;
  branch_info_t bi_p0;
  logic [31:0]  wdog_d;

  logic         vld_p1;
  if_reason_e   reason_p1;
  logic [63:0]  pc_p1;
  branch_info_t bi_p1;
  logic         busy_p1;
  logic         timeout_p1;
  logic [63:0]  fence_pc_q;
  logic [31:0]  wdog_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= RDR_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RDR_IDLE: begin
        if (!trap_valid_i && fence_valid_i && fence_kind_i == FENCE_KIND_I && !dcache_idle_i)
          state_d = RDR_DRAIN;
      end
      RDR_DRAIN: begin
        if (trap_valid_i)       state_d = RDR_IDLE;
        else if (dcache_idle_i) state_d = RDR_ISSUE;
      end
      RDR_ISSUE: state_d = RDR_IDLE;
      default:   state_d = RDR_IDLE;
    endcase
  end

  // Stage p0: arbitration and next output values
  always_comb begin
    vld_p0      = 1'b0;
    reason_p0   = reason_p1;
    pc_p0       = pc_p1;
    trap_acc    = 1'b0;
    fence_issue = 1'b0;
    mis_acc     = 1'b0;
    drain_enter = 1'b0;
    unique case (state_q)
      RDR_IDLE: begin
        if (trap_valid_i) begin
          trap_acc  = 1'b1;
          vld_p0    = 1'b1;
          reason_p0 = IF_TRAP;
          pc_p0     = trap_pc_i;
        end else if (fence_valid_i) begin
          if (fence_kind_i == FENCE_KIND_VMA) begin
            fence_issue = 1'b1;
            vld_p0      = 1'b1;
            reason_p0   = IF_SATP_CHANGED;
            pc_p0       = fence_pc_i;
          end else if (dcache_idle_i) begin
            fence_issue = 1'b1;
            vld_p0      = 1'b1;
            reason_p0   = IF_FENCE_I;
            pc_p0       = fence_pc_i;
          end else begin
            drain_enter = 1'b1;
          end
        end else if (mispred_valid_i) begin
          mis_acc   = 1'b1;
          vld_p0    = 1'b1;
          reason_p0 = IF_MISPREDICT;
          pc_p0     = mispred_pc_i;
        end
      end
      RDR_DRAIN: begin
        if (trap_valid_i) begin
          trap_acc  = 1'b1;
          vld_p0    = 1'b1;
          reason_p0 = IF_TRAP;
          pc_p0     = trap_pc_i;
        end
      end
      RDR_ISSUE: begin
        fence_issue = 1'b1;
        vld_p0      = 1'b1;
        reason_p0   = IF_FENCE_I;
        pc_p0       = fence_pc_q;
      end
      default: ;
    endcase
  end

  // Dropped mispredicts and accepted traps must not train the predictors.
  always_comb begin
    bi_p0 = branch_info_i;
    if (trap_acc || (mispred_valid_i && !mis_acc)) bi_p0.branch_type = BRANCH_NONE;
  end

  assign wdog_d = sat_inc(wdog_q);

  // Stage p1: registered outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_p1     <= 1'b0;
      reason_p1  <= IF_PREFETCH;
      pc_p1      <= '0;
      bi_p1      <= '{branch_type: BRANCH_NONE, pc: '0, compressed: 1'b0};
      busy_p1    <= 1'b0;
      timeout_p1 <= 1'b0;
      fence_pc_q <= '0;
      wdog_q     <= '0;
    end else begin
      vld_p1    <= vld_p0;
      reason_p1 <= reason_p0;
      pc_p1     <= pc_p0 & ~64'd1;
      bi_p1     <= bi_p0;
      // Held through the redirect cycle so issue resumes only behind the new PC.
      busy_p1   <= (state_q != RDR_IDLE) || (state_d != RDR_IDLE);
      if (drain_enter) begin
        fence_pc_q <= fence_pc_i;
        wdog_q     <= '0;
      end else if (state_q == RDR_DRAIN) begin
        wdog_q <= wdog_d;
        if (TimeoutEn && wdog_d >= TimeoutW) timeout_p1 <= 1'b1;
      end
    end
  end

  logic [2:0] perf_inc;
  always_comb begin
    perf_inc                 = '0;
    perf_inc[PerfSrcTrap]    = trap_acc;
    perf_inc[PerfSrcFence]   = fence_issue;
    perf_inc[PerfSrcMispred] = mis_acc;
  end

  muntjac_redirect_perf u_perf (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .inc_i  (perf_inc),
    .cnt_o  (perf_cnt_o)
  );

  assign redirect_valid_o  = vld_p1;
  assign redirect_reason_o = reason_p1;
  assign redirect_pc_o     = pc_p1;
  assign branch_info_o     = bi_p1;
  assign busy_o            = busy_p1;
  assign drain_timeout_o   = timeout_p1;

endmodule

// File: tb/tb_muntjac_redirect_ctrl.sv
// Directed + randomized bench for muntjac_redirect_ctrl against a pending-fence reference model.
module tb_muntjac_redirect_ctrl;
  import muntjac_pkg::*;

  localparam int unsigned TMO = 8;

  logic             clk_i = 1'b0;
  logic             rst_ni;
  logic             trap_valid_i;
  logic [63:0]      trap_pc_i;
  logic             fence_valid_i;
  fence_kind_e      fence_kind_i;
  logic [63:0]      fence_pc_i;
  logic             mispred_valid_i;
  logic [63:0]      mispred_pc_i;
  branch_info_t     branch_info_i;
  logic             dcache_idle_i;
  logic             busy_o;
  logic             redirect_valid_o;
  if_reason_e       redirect_reason_o;
  logic [63:0]      redirect_pc_o;
  branch_info_t     branch_info_o;
  logic             drain_timeout_o;
  logic [2:0][31:0] perf_cnt_o;

  muntjac_redirect_ctrl #(.DrainTimeout(TMO)) dut (
    .clk_i             (clk_i),
    .rst_ni            (rst_ni),
    .trap_valid_i      (trap_valid_i),
    .trap_pc_i         (trap_pc_i),
    .fence_valid_i     (fence_valid_i),
    .fence_kind_i      (fence_kind_i),
    .fence_pc_i        (fence_pc_i),
    .mispred_valid_i   (mispred_valid_i),
    .mispred_pc_i      (mispred_pc_i),
    .branch_info_i     (branch_info_i),
    .dcache_idle_i     (dcache_idle_i),
    .busy_o            (busy_o),
    .redirect_valid_o  (redirect_valid_o),
    .redirect_reason_o (redirect_reason_o),
    .redirect_pc_o     (redirect_pc_o),
    .branch_info_o     (branch_info_o),
    .drain_timeout_o   (drain_timeout_o),
    .perf_cnt_o        (perf_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model: a fence waiting for the D$, and one ready to issue.
  bit          m_pend, m_rdy, m_tmo;
  int unsigned m_dcnt;
  logic [63:0] m_lpc;
  int unsigned m_n_trap, m_n_fence, m_n_mis;
  bit          e_valid, e_busy;
  if_reason_e  e_reason;
  logic [63:0] e_pc;
  branch_info_t e_bi;

  task automatic chk(input string tag, input logic [127:0] o, input logic [127:0] e);
    n_cmp++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  function automatic void model_reset();
    m_pend = 0; m_rdy = 0; m_tmo = 0; m_dcnt = 0; m_lpc = '0;
    m_n_trap = 0; m_n_fence = 0; m_n_mis = 0;
    e_valid = 0; e_busy = 0; e_reason = IF_PREFETCH; e_pc = '0;
    e_bi = '{branch_type: BRANCH_NONE, pc: '0, compressed: 1'b0};
  endfunction

  function automatic void pulse(input if_reason_e r, input logic [63:0] pc);
    e_valid = 1; e_reason = r; e_pc = {pc[63:1], 1'b0};
  endfunction

  function automatic void model_step(input bit tv, input logic [63:0] tpc, input bit fv,
                                     input fence_kind_e fk, input logic [63:0] fpc, input bit mv,
                                     input logic [63:0] mpc, input branch_info_t bi, input bit di);
    bit was_busy, trap_ok, mis_ok;
    was_busy = m_pend | m_rdy;
    trap_ok = 0; mis_ok = 0; e_valid = 0;
    if (m_rdy) begin
      pulse(IF_FENCE_I, m_lpc); m_rdy = 0; m_n_fence++;
    end else if (m_pend) begin
      if (m_dcnt != 32'hFFFF_FFFF) m_dcnt++;
      if (TMO != 0 && m_dcnt >= TMO) m_tmo = 1;
      if (tv) begin
        pulse(IF_TRAP, tpc); m_pend = 0; trap_ok = 1; m_n_trap++;
      end else if (di) begin
        m_pend = 0; m_rdy = 1;
      end
    end else if (tv) begin
      pulse(IF_TRAP, tpc); trap_ok = 1; m_n_trap++;
    end else if (fv) begin
      if (fk == FENCE_KIND_VMA) begin pulse(IF_SATP_CHANGED, fpc); m_n_fence++; end
      else if (di) begin pulse(IF_FENCE_I, fpc); m_n_fence++; end
      else begin m_pend = 1; m_dcnt = 0; m_lpc = fpc; end
    end else if (mv) begin
      pulse(IF_MISPREDICT, mpc); mis_ok = 1; m_n_mis++;
    end
    e_busy = was_busy | m_pend | m_rdy;
    e_bi = bi;
    if (trap_ok || (mv && !mis_ok)) e_bi.branch_type = BRANCH_NONE;
  endfunction

  function automatic logic [95:0] exp_perf();
`ifdef MUNTJAC_REDIRECT_PERF_EN
    return {32'(m_n_trap), 32'(m_n_fence), 32'(m_n_mis)};
`else
    return '0;
`endif
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".valid"},   128'(redirect_valid_o),  128'(e_valid));
    chk({tag, ".reason"},  128'(redirect_reason_o), 128'(e_reason));
    chk({tag, ".pc"},      128'(redirect_pc_o),     128'(e_pc));
    chk({tag, ".busy"},    128'(busy_o),            128'(e_busy));
    chk({tag, ".binfo"},   128'(branch_info_o),     128'(e_bi));
    chk({tag, ".timeout"}, 128'(drain_timeout_o),   128'(m_tmo));
    chk({tag, ".perf"},    128'(perf_cnt_o),        128'(exp_perf()));
  endtask

  task automatic step(input string tag, input bit tv, input logic [63:0] tpc, input bit fv,
                      input fence_kind_e fk, input logic [63:0] fpc, input bit mv,
                      input logic [63:0] mpc, input branch_info_t bi, input bit di);
    trap_valid_i = tv; trap_pc_i = tpc; fence_valid_i = fv; fence_kind_i = fk;
    fence_pc_i = fpc; mispred_valid_i = mv; mispred_pc_i = mpc; branch_info_i = bi;
    dcache_idle_i = di;
    model_step(tv, tpc, fv, fk, fpc, mv, mpc, bi, di);
    @(posedge clk_i);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset(input string tag);
    rst_ni = 1'b0;
    #2;
    model_reset();
    check_all(tag);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
  endtask

  branch_info_t bi_t, bi_z;

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "time limit");
  end

  initial begin
    int busy_n, pulse_n;
    rst_ni = 1'b0;
    trap_valid_i = 0; trap_pc_i = '0; fence_valid_i = 0; fence_kind_i = FENCE_KIND_I;
    fence_pc_i = '0; mispred_valid_i = 0; mispred_pc_i = '0; dcache_idle_i = 1;
    bi_z = '{branch_type: BRANCH_NONE, pc: '0, compressed: 1'b0};
    bi_t = '{branch_type: BRANCH_TAKEN, pc: 64'h1234_5678, compressed: 1'b1};
    branch_info_i = bi_z;
    @(posedge clk_i); #1;
    do_reset("reset");

    // 1: all three sources at once
    step("t1", 1, 64'hA000_0100, 1, FENCE_KIND_VMA, 64'hB000_0000, 1, 64'hC000_0000, bi_t, 1);
    chk("t1.reason_trap", 128'(redirect_reason_o), 128'(IF_TRAP));
    chk("t1.btype_none", 128'(branch_info_o.branch_type), 128'(BRANCH_NONE));
    step("t1.idle", 0, '0, 0, FENCE_KIND_I, '0, 0, '0, bi_z, 1);
    chk("t1.single_pulse", 128'(redirect_valid_o), 128'(0));

    // 2: fence.i with D$ busy for 5 cycles
    busy_n = 0; pulse_n = 0;
    step("t2.acc", 0, '0, 1, FENCE_KIND_I, 64'h0000_4444, 0, '0, bi_z, 0);
    busy_n += int'(busy_o);
    for (int i = 0; i < 4; i++) begin
      step("t2.drain", 0, '0, 0, FENCE_KIND_I, '0, 1, 64'h9999, bi_t, 0);
      busy_n += int'(busy_o);
    end
    for (int i = 0; i < 4; i++) begin
      step("t2.wait", 0, '0, 0, FENCE_KIND_I, '0, 0, '0, bi_z, 1);
      busy_n += int'(busy_o);
      if (redirect_valid_o) pulse_n = i;
    end
    chk("t2.busy_cycles", 128'(busy_n), 128'(7));
    chk("t2.pulse_slot", 128'(pulse_n), 128'(1));

    // 3: trap aborts a drain
    step("t3.acc", 0, '0, 1, FENCE_KIND_I, 64'h5550, 0, '0, bi_z, 0);
    step("t3.d1", 0, '0, 0, FENCE_KIND_I, '0, 0, '0, bi_z, 0);
    step("t3.trap", 1, 64'h7770, 0, FENCE_KIND_I, '0, 0, '0, bi_t, 0);
    chk("t3.reason", 128'(redirect_reason_o), 128'(IF_TRAP));
    pulse_n = 0;
    for (int i = 0; i < 4; i++) begin
      step("t3.after", 0, '0, 0, FENCE_KIND_I, '0, 0, '0, bi_z, 1);
      pulse_n += int'(redirect_valid_o);
    end
    chk("t3.no_fence", 128'(pulse_n), 128'(0));

    // 4: watchdog
    step("t4.acc", 0, '0, 1, FENCE_KIND_I, 64'h6660, 0, '0, bi_z, 0);
    for (int i = 1; i <= 10; i++) begin
      step("t4.drain", 0, '0, 0, FENCE_KIND_I, '0, 0, '0, bi_z, 0);
      if (i == 7) chk("t4.not_yet", 128'(drain_timeout_o), 128'(0));
      if (i == 8) chk("t4.rise", 128'(drain_timeout_o), 128'(1));
    end
    step("t4.idle", 0, '0, 0, FENCE_KIND_I, '0, 0, '0, bi_z, 1);
    step("t4.issue", 0, '0, 0, FENCE_KIND_I, '0, 0, '0, bi_z, 1);
    chk("t4.fence_pc", 128'(redirect_pc_o), 128'(64'h6660));
    chk("t4.sticky", 128'(drain_timeout_o), 128'(1));

    // 5: odd mispredict target
    step("t5", 0, '0, 0, FENCE_KIND_I, '0, 1, 64'h8000_0003, bi_t, 1);
    chk("t5.pc", 128'(redirect_pc_o), 128'(64'h8000_0002));
    chk("t5.binfo", 128'(branch_info_o), 128'(bi_t));

    // reset during drain discards the fence
    step("rd.acc", 0, '0, 1, FENCE_KIND_I, 64'h3330, 0, '0, bi_z, 0);
    step("rd.d1", 0, '0, 0, FENCE_KIND_I, '0, 0, '0, bi_z, 0);
    do_reset("rd.reset");
    for (int i = 0; i < 3; i++) step("rd.after", 0, '0, 0, FENCE_KIND_I, '0, 0, '0, bi_z, 1);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      branch_info_t rb;
      rb.branch_type = branch_type_e'($urandom_range(0, 5));
      rb.pc = {$urandom, $urandom};
      rb.compressed = 1'($urandom_range(0, 1));
      step("rnd", $urandom_range(0, 9) == 0, {$urandom, $urandom},
           $urandom_range(0, 5) == 0, fence_kind_e'($urandom_range(0, 1)), {$urandom, $urandom},
           $urandom_range(0, 3) == 0, {$urandom, $urandom}, rb, $urandom_range(0, 3) == 0);
    end

    // 6: perf counters
    do_reset("t6.reset");
    for (int i = 0; i < 3; i++) step("t6.trap", 1, 64'h100 + 64'(i), 0, FENCE_KIND_I, '0, 0, '0, bi_z, 1);
    for (int i = 0; i < 2; i++) step("t6.mis", 0, '0, 0, FENCE_KIND_I, '0, 1, 64'h200, bi_t, 1);
`ifdef MUNTJAC_REDIRECT_PERF_EN
    chk("t6.perf", 128'(perf_cnt_o), 128'({32'd3, 32'd0, 32'd2}));
`else
    chk("t6.perf", 128'(perf_cnt_o), 128'(96'd0));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
